tick_gen_multi: RTL and testbench

Parametrised multi-channel tick generator: the successor of the fixed 25 Hz divider. Each channel produces a registered, glitch-free one-cycle tick and a 50 % square wave from a runtime-programmable terminal count. Global enable and synchronous restart are provided. It sits beside the game timing logic and feeds frame-rate, scroll-speed and score-blink timing from one block with per-channel rates.

---
 rtl/tick_gen_multi.sv | 77 +++++++
 tb/tb_tick_gen_multi.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/tick_gen_multi.sv
// Multi-channel tick generator: per-channel programmable terminal count producing
// a registered one-cycle tick and a 50 % square wave, with shared enable and restart.
module tick_gen_multi #(
  parameter int unsigned CNT_W     = 28,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned CH_W      = 1,
  parameter int unsigned DIV_RESET = 4000000
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              div_wr,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CNT_W-1:0]  div_data,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  logic [CNT_W-1:0]  cnt   [NUM_CH];
  logic [CNT_W-1:0]  tc    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  tc_d  [NUM_CH];
  logic [NUM_CH-1:0] tick_d;
  logic [NUM_CH-1:0] sq_d;
  logic              ch_ok;

  assign ch_ok = (32'(div_ch) < NUM_CH);

  // Next-state per channel: clr beats en; a tc write clamps the counter so it
  // can never run past the new terminal count.
  always_comb begin
    tick_d = '0;
    sq_d   = sq;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cnt_d[i] = cnt[i];
      tc_d[i]  = tc[i];
      if (clr) begin
        cnt_d[i] = '0;
        sq_d[i]  = 1'b0;
      end else if (en) begin
        if (cnt[i] == tc[i]) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          sq_d[i]   = ~sq[i];
        end else begin
          cnt_d[i] = cnt[i] + CNT_W'(1);
        end
      end
      if (div_wr && ch_ok && (div_ch == CH_W'(i))) begin
        tc_d[i] = div_data;
        if (cnt_d[i] > div_data) begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt[i] <= '0;
        tc[i]  <= CNT_W'(DIV_RESET);
      end
      tick <= '0;
      sq   <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt[i] <= cnt_d[i];
        tc[i]  <= tc_d[i];
      end
      tick <= tick_d;
      sq   <= sq_d;
    end
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed bench for tick_gen_multi with DIV_RESET=4, two channels, 2-bit select.
module tb_tick_gen_multi;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned NUM_CH = 2;
  localparam int unsigned CH_W   = 2;

  logic              clk_in = 1'b0;
  logic              rst_n;
  logic              en;
  logic              clr;
  logic              div_wr;
  logic [CH_W-1:0]   div_ch;
  logic [CNT_W-1:0]  div_data;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  tick_gen_multi #(
    .CNT_W(CNT_W), .NUM_CH(NUM_CH), .CH_W(CH_W), .DIV_RESET(4)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .clr(clr), .div_wr(div_wr),
    .div_ch(div_ch), .div_data(div_data), .tick(tick), .sq(sq)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock edge, then sample tick and sq 1 ns later.
  task automatic step(input string ph, input logic [1:0] et, input logic [1:0] es);
    @(posedge clk_in);
    #1;
    cyc++;
    check($sformatf("%s_tick_c%0d", ph, cyc), tick, et);
    check($sformatf("%s_sq_c%0d", ph, cyc), sq, es);
  endtask

  // Reset, then release on a falling edge so the next rising edge is cycle 1.
  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; div_wr = 1'b0; div_ch = '0; div_data = '0;
    #3;
    check("reset_tick", tick, 2'b00);
    check("reset_sq", sq, 2'b00);
    @(negedge clk_in);
    rst_n = 1'b1;
    en    = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    // Basic rate: tc=4 on both channels.
    do_reset();
    for (int k = 1; k <= 15; k++)
      step("base", (k % 5 == 0) ? 2'b11 : 2'b00, ((k / 5) % 2 == 1) ? 2'b11 : 2'b00);

    // Asynchronous reset while tick and sq are high.
    rst_n = 1'b0;
    #1;
    check("async_rst_tick", tick, 2'b00);
    check("async_rst_sq", sq, 2'b00);
    @(negedge clk_in);
    rst_n = 1'b1;
    cyc   = 0;

    // ch1 tc -> 1 written while its count is past 1; out-of-range select ignored.
    step("wr", 2'b00, 2'b00);
    step("wr", 2'b00, 2'b00);
    div_wr = 1'b1; div_ch = 2'd1; div_data = 8'd1;
    step("wr", 2'b00, 2'b00);
    div_wr = 1'b0;
    step("wr", 2'b00, 2'b00);
    step("wr", 2'b11, 2'b11);
    div_wr = 1'b1; div_ch = 2'd2; div_data = 8'd0;
    step("wr", 2'b00, 2'b11);
    div_wr = 1'b0;
    step("wr", 2'b10, 2'b01);
    step("wr", 2'b00, 2'b01);
    step("wr", 2'b10, 2'b11);
    step("wr", 2'b01, 2'b10);
    step("wr", 2'b10, 2'b00);

    // ch0 tc -> 0: ticks every enabled cycle; en gap freezes sq.
    div_wr = 1'b1; div_ch = 2'd0; div_data = 8'd0;
    step("tc0", 2'b00, 2'b00);
    div_wr = 1'b0;
    step("tc0", 2'b11, 2'b11);
    step("tc0", 2'b01, 2'b10);
    step("tc0", 2'b11, 2'b01);
    en = 1'b0;
    step("tc0", 2'b00, 2'b01);
    step("tc0", 2'b00, 2'b01);
    step("tc0", 2'b00, 2'b01);
    en = 1'b1;
    step("tc0", 2'b01, 2'b00);
    step("tc0", 2'b11, 2'b11);

    // en low for cycles 3..6 delays the tick to 9; en dropped at cnt==tc.
    do_reset();
    step("gap", 2'b00, 2'b00);
    step("gap", 2'b00, 2'b00);
    en = 1'b0;
    for (int k = 3; k <= 6; k++) step("gap", 2'b00, 2'b00);
    en = 1'b1;
    step("gap", 2'b00, 2'b00);
    step("gap", 2'b00, 2'b00);
    step("gap", 2'b11, 2'b11);
    for (int k = 10; k <= 13; k++) step("gap", 2'b00, 2'b11);
    step("gap", 2'b11, 2'b00);
    for (int k = 15; k <= 18; k++) step("gap", 2'b00, 2'b00);
    en = 1'b0;
    step("gap", 2'b00, 2'b00);
    en = 1'b1;
    step("gap", 2'b11, 2'b11);

    // clr together with a ch0 write of tc=2 while sq is high.
    do_reset();
    for (int k = 1; k <= 4; k++) step("clr", 2'b00, 2'b00);
    step("clr", 2'b11, 2'b11);
    step("clr", 2'b00, 2'b11);
    clr = 1'b1; div_wr = 1'b1; div_ch = 2'd0; div_data = 8'd2;
    step("clr", 2'b00, 2'b00);
    clr = 1'b0; div_wr = 1'b0;
    step("clr", 2'b00, 2'b00);
    step("clr", 2'b00, 2'b00);
    step("clr", 2'b01, 2'b01);
    step("clr", 2'b00, 2'b01);
    step("clr", 2'b10, 2'b11);
    step("clr", 2'b01, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
